// File: rtl/pp_serial_accum_if.sv
// Handshake bundle between the partial-product generator, the serial accumulator and its consumer.
// Carries the optional ovf flag when PP_ACCUM_OVF_EN is defined.
interface pp_serial_accum_if #(
  parameter int unsigned W = 8
);
  logic           start;
  logic           pp_valid;
  logic           pp_ready;
  logic [W:0]     pp_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef PP_ACCUM_OVF_EN
  logic           ovf;
`endif

  modport master (
    output start, pp_valid, pp_in, out_ready,
`ifdef PP_ACCUM_OVF_EN
    input  ovf,
`endif
    input  pp_ready, out_valid, product, busy
  );

  modport slave (
    input  start, pp_valid, pp_in, out_ready,
`ifdef PP_ACCUM_OVF_EN
    output ovf,
`endif
    output pp_ready, out_valid, product, busy
  );
endinterface

// File: rtl/pp_serial_accum.sv
// Serial shift-and-add accumulator of W LSB-first partial products into a 2W-bit product.
// Optional PP_ACCUM_OVF_EN adds an ovf output flagging a carry into accumulator bit 2W.
module pp_serial_accum #(
  parameter int unsigned W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pp_serial_accum_if.slave      bus
);
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e          state_q;
  logic [2*W:0]    acc_q;
  logic [CntW-1:0] cnt_q;
  logic [2*W-1:0]  product_q;
  logic            pp_ready_q;
  logic            out_valid_q;
  logic            busy_q;
`ifdef PP_ACCUM_OVF_EN
  logic            ovf_q;
`endif

  logic [2*W:0] pp_ext;
  logic [2*W:0] acc_sum;

  // 2W+1-bit accumulator keeps pp_in[W] headroom from wrapping before the final truncation.
  always_comb begin
    pp_ext  = {{W{1'b0}}, bus.pp_in};
    acc_sum = acc_q + (pp_ext << cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      pp_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PP_ACCUM_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            cnt_q      <= '0;
            pp_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StAccum: begin
          if (bus.pp_valid && pp_ready_q) begin
            acc_q     <= acc_sum;
            product_q <= acc_sum[2*W-1:0];
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == CntW'(W - 1)) begin
              state_q     <= StDone;
              pp_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
`ifdef PP_ACCUM_OVF_EN
              ovf_q       <= acc_sum[2*W];
`endif
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PP_ACCUM_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= StIdle;
          pp_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pp_ready  = pp_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
`ifdef PP_ACCUM_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_pp_serial_accum.sv
// Table-driven bench for pp_serial_accum with a product scoreboard and reset/hold corner cases.
// Checks ovf as well when PP_ACCUM_OVF_EN is defined.
module tb_pp_serial_accum;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pp_serial_accum_if #(.W(W)) bus ();

  pp_serial_accum #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0][8:0] pp;
    int              stall_at;
    int              hold;
    logic [15:0]     exp;
    logic            exp_ovf;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  logic [15:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare product at every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'(bus.product), 32'hDEAD);
      end else begin
        chk("sb_product", 32'(bus.product), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic run_op(input vec_t v);
    bus.start     = 1'b1;
    bus.pp_valid  = 1'b1;
    bus.pp_in     = 9'h1AB;  // must not be consumed in the start cycle
    bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("accum_pp_ready", 32'(bus.pp_ready), 32'd1);
    chk("accum_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == v.stall_at) begin
        for (int s = 0; s < 3; s++) begin
          bus.pp_valid = 1'b0;
          bus.pp_in    = 9'h1FF;
          tick();
          chk("stall_pp_ready", 32'(bus.pp_ready), 32'd1);
          chk("stall_out_valid", 32'(bus.out_valid), 32'd0);
        end
      end
      bus.pp_valid = 1'b1;
      bus.pp_in    = v.pp[i];
      tick();
    end
    bus.pp_valid = 1'b0;
    sb_q.push_back(v.exp);
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    chk("done_pp_ready", 32'(bus.pp_ready), 32'd0);
    chk("done_product", 32'(bus.product), 32'(v.exp));
`ifdef PP_ACCUM_OVF_EN
    chk("done_ovf", 32'(bus.ovf), 32'(v.exp_ovf));
`endif
    for (int h = 0; h < v.hold; h++) begin
      bus.start = (h == 1);
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_product", 32'(bus.product), 32'(v.exp));
    end
    // start during the handshake cycle is ignored
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_pp_ready", 32'(bus.pp_ready), 32'd0);
    chk("idle_product_hold", 32'(bus.product), 32'(v.exp));
`ifdef PP_ACCUM_OVF_EN
    chk("idle_ovf", 32'(bus.ovf), 32'd0);
`endif
    tick();
    chk("idle_stays", 32'(bus.busy), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t v_ff;

  initial begin
    vecs[0] = '{pp: {8{9'h0FF}}, stall_at: -1, hold: 0, exp: 16'hFE01, exp_ovf: 1'b0};
    vecs[1] = '{pp: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h05A, 9'h05A},
                stall_at: -1, hold: 5, exp: 16'h010E, exp_ovf: 1'b0};
    vecs[2] = '{pp: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h05A, 9'h05A},
                stall_at: 4, hold: 0, exp: 16'h010E, exp_ovf: 1'b0};
    vecs[3] = '{pp: {8{9'h000}}, stall_at: -1, hold: 0, exp: 16'h0000, exp_ovf: 1'b0};
    vecs[4] = '{pp: {8{9'h001}}, stall_at: 0, hold: 1, exp: 16'h00FF, exp_ovf: 1'b0};
    vecs[5] = '{pp: {9'h0FF, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0FF},
                stall_at: 2, hold: 0, exp: 16'h807F, exp_ovf: 1'b0};
    vecs[6] = '{pp: {8{9'h1FF}}, stall_at: -1, hold: 2, exp: 16'hFD01, exp_ovf: 1'b1};
    v_ff = vecs[0];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.pp_valid = 1'b0;
    bus.pp_in = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pp_ready", 32'(bus.pp_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);

    for (int k = 0; k < 7; k++) run_op(vecs[k]);

    // Abort mid-operation: 4 accepts then reset, no result may appear.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pp_valid = 1'b1;
      bus.pp_in    = 9'h1FF;
      tick();
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.pp_valid = 1'b0;
    chk("abort_pp_ready", 32'(bus.pp_ready), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    tick();
    chk("abort_no_restart", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;
    run_op(v_ff);

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
